// File: rtl/corefifo_pkg.sv
// Shared types and helpers for the async FIFO pointer-crossing logic.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package corefifo_pkg;

   // Default address width; pointers carry one extra wrap bit.
   localparam int DEF_ADDRWIDTH = 3;
   localparam int PTRW          = DEF_ADDRWIDTH + 1;

   // Widest pointer the helpers handle. Narrower values are zero-extended.
   // Leading zeros leave both Gray and binary encodings unchanged, so the
   // helpers need no width argument.
   localparam int MAXW = 16;

   // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
   function automatic logic [MAXW-1:0] gray2bin(input logic [MAXW-1:0] g);
      logic [MAXW-1:0] b;
      b[MAXW-1] = g[MAXW-1];
      for (int i = MAXW - 1; i > 0; i--) begin
         b[i-1] = b[i] ^ g[i-1];
      end
      return b;
   endfunction

   // Binary to Gray: adjacent binary values differ in exactly one Gray bit.
   function automatic logic [MAXW-1:0] bin2gray(input logic [MAXW-1:0] b);
      return b ^ (b >> 1);
   endfunction

   // True when more than one bit is set. Clearing the lowest set bit leaves
   // a non-zero value only if a second bit was set.
   function automatic logic popcount_gt1(input logic [MAXW-1:0] x);
      return (x & (x - MAXW'(1))) != '0;
   endfunction

endpackage

// File: rtl/corefifo_gray2bin_comb.sv
// Combinational Gray-to-binary converter for one pointer.
// Latency: zero cycles (pure combinational).
// Backpressure: none; output follows input continuously.
module corefifo_gray2bin_comb
   import corefifo_pkg::*;
#(
   parameter int W = PTRW
) (
   input  logic [W-1:0] gray,
   output logic [W-1:0] bin
);

   logic [MAXW-1:0] bin_full;
   logic            unused_hi;

   // The package converter runs at its full width; the zero-extended top
   // bits always decode to zero and are dropped.
   assign bin_full  = gray2bin(MAXW'(gray));
   assign bin       = bin_full[W-1:0];
   assign unused_hi = ^bin_full[MAXW-1:W];

   generate
      if (W < 1 || W >= MAXW) begin : g_bad_width
         $error("corefifo_gray2bin_comb: W must be in 1..MAXW-1");
      end
   endgenerate

endmodule

// File: rtl/corefifo_gray_ptr_sync.sv
// Syncs a remote Gray pointer into clk, converts it to binary, and derives level and flags.
// Latency: remote change SYNC_STAGES+1 edges to outputs; local pointer change one edge.
// Backpressure: none; flags and level are the backpressure for the FIFO ports.
module corefifo_gray_ptr_sync
   import corefifo_pkg::*;
#(
   parameter int ADDRWIDTH   = DEF_ADDRWIDTH,
   parameter int SYNC_STAGES = 2,
   parameter int AFULL_TH    = 6,
   parameter int AEMPTY_TH   = 1,
   parameter int CHECK_GRAY  = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [ADDRWIDTH:0]   gray_in,
   input  logic [ADDRWIDTH:0]   ptr_local,
   input  logic                 err_clr,
   output logic [ADDRWIDTH:0]   bin_out,
   output logic                 ptr_upd,
   output logic [ADDRWIDTH:0]   level,
   output logic                 empty,
   output logic                 aempty,
   output logic                 full,
   output logic                 afull,
   output logic                 gray_err
);

   localparam int PW = ADDRWIDTH + 1;

   localparam logic [PW-1:0] AFULL_V    = PW'(AFULL_TH);
   localparam logic [PW-1:0] AEMPTY_V   = PW'(AEMPTY_TH);
   // Flag values for a level of zero, used as reset values.
   localparam logic          AFULL_RST  = (AFULL_TH <= 0);
   localparam logic          AEMPTY_RST = (AEMPTY_TH >= 0);

   // Elaboration-time sanity of the configuration.
   generate
      if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
         $error("corefifo_gray_ptr_sync: SYNC_STAGES must be 2..4");
      end
      if (AEMPTY_TH >= AFULL_TH) begin : g_bad_th_order
         $error("corefifo_gray_ptr_sync: AEMPTY_TH must be below AFULL_TH");
      end
      if (AFULL_TH > (1 << ADDRWIDTH)) begin : g_bad_afull
         $error("corefifo_gray_ptr_sync: AFULL_TH exceeds FIFO depth");
      end
   endgenerate

   // Synchroniser chain: plain flop-to-flop, nothing between stages so each
   // stage gets a full cycle to resolve metastability.
   generate
      for (genvar i = 0; i < SYNC_STAGES; i++) begin : g_sync
         logic [PW-1:0] d;
         logic [PW-1:0] q;

         if (i == 0) begin : g_first
            assign d = gray_in;
         end else begin : g_next
            assign d = g_sync[i-1].q;
         end

         // One synchroniser stage.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               q <= '0;
            end else begin
               q <= d;
            end
         end
      end
   endgenerate

   logic [PW-1:0] g;
   logic [PW-1:0] prev_g;
   logic [PW-1:0] bin_c;
   logic [PW-1:0] lvl_c;
   logic          err_set;

   assign g = g_sync[SYNC_STAGES-1].q;

   corefifo_gray2bin_comb #(
      .W    (PW)
   ) u_gray2bin (
      .gray (g),
      .bin  (bin_c)
   );

   // Level and Gray-integrity check from the freshly converted pointer.
   // Level wraps modulo 2^PW; a value past the depth is reported, not clamped.
   always_comb begin
      lvl_c   = bin_c - ptr_local;
      err_set = 1'b0;
      if (CHECK_GRAY != 0) begin
         err_set = popcount_gt1(MAXW'(g ^ prev_g));
      end
   end

   // Registered pointer, update strobe, level and status flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_g  <= '0;
         bin_out <= '0;
         ptr_upd <= 1'b0;
         level   <= '0;
         empty   <= 1'b1;
         aempty  <= AEMPTY_RST;
         full    <= 1'b0;
         afull   <= AFULL_RST;
      end else begin
         prev_g  <= g;
         bin_out <= bin_c;
         ptr_upd <= (bin_c != bin_out);
         level   <= lvl_c;
         empty   <= (lvl_c == '0);
         // MSB set means level >= 2^ADDRWIDTH, including illegal overfill.
         full    <= lvl_c[ADDRWIDTH];
         aempty  <= (lvl_c <= AEMPTY_V);
         afull   <= (lvl_c >= AFULL_V);
      end
   end

   // Sticky Gray error; a new error in the clearing cycle takes priority.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gray_err <= 1'b0;
      end else if (err_set) begin
         gray_err <= 1'b1;
      end else if (err_clr) begin
         gray_err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_corefifo_gray_ptr_sync.sv
// Bench for corefifo_gray_ptr_sync: directed scenarios plus random pointer traffic.
// Latency: outputs compared at every falling edge against a delay-history model.
// Backpressure: n/a.
module tb_corefifo_gray_ptr_sync;
   import corefifo_pkg::*;

   localparam int AW = 3;
   localparam int S  = 2;
   localparam int AF = 6;
   localparam int AE = 1;
   localparam int PW = AW + 1;

   logic          clk       = 1'b0;
   logic          rst_n     = 1'b0;
   logic [PW-1:0] gray_in   = 4'b0101;
   logic [PW-1:0] ptr_local = '0;
   logic          err_clr   = 1'b0;

   logic [PW-1:0] bin_out;
   logic          ptr_upd;
   logic [PW-1:0] level;
   logic          empty, aempty, full, afull, gray_err;

   corefifo_gray_ptr_sync #(
      .ADDRWIDTH   (AW),
      .SYNC_STAGES (S),
      .AFULL_TH    (AF),
      .AEMPTY_TH   (AE),
      .CHECK_GRAY  (1)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .gray_in   (gray_in),
      .ptr_local (ptr_local),
      .err_clr   (err_clr),
      .bin_out   (bin_out),
      .ptr_upd   (ptr_upd),
      .level     (level),
      .empty     (empty),
      .aempty    (aempty),
      .full      (full),
      .afull     (afull),
      .gray_err  (gray_err)
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model: a history of sampled remote Gray values. The value
   // seen by the output registers at edge k is the one sampled at edge k-S.
   logic [PW-1:0] h [0:S+1];
   logic [PW-1:0] m_bin = '0;
   logic [PW-1:0] m_lvl = '0;
   logic          m_upd = 1'b0;
   logic          m_err = 1'b0;
   logic [PW-1:0] mb;

   // Decode Gray by searching for the binary value that encodes to it.
   function automatic logic [PW-1:0] decode(input logic [PW-1:0] gv);
      logic [MAXW-1:0] cand;
      logic [PW-1:0]   res;
      res = '0;
      for (int b = 0; b < (1 << PW); b++) begin
         cand = bin2gray(MAXW'(b));
         if (cand[PW-1:0] == gv) res = PW'(b);
      end
      return res;
   endfunction

   function automatic logic [PW-1:0] enc(input logic [PW-1:0] b);
      logic [MAXW-1:0] t;
      t = bin2gray(MAXW'(b));
      return t[PW-1:0];
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i <= S + 1; i++) h[i] = '0;
         m_bin = '0;
         m_lvl = '0;
         m_upd = 1'b0;
         m_err = 1'b0;
      end else begin
         for (int i = S + 1; i > 0; i--) h[i] = h[i-1];
         h[0]  = gray_in;
         mb    = decode(h[S]);
         m_upd = (mb != m_bin);
         m_bin = mb;
         m_lvl = mb - ptr_local;
         if ($countones(h[S] ^ h[S+1]) > 1) m_err = 1'b1;
         else if (err_clr)                  m_err = 1'b0;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_model();
      chk("m_bin_out",  32'(bin_out),  32'(m_bin));
      chk("m_ptr_upd",  32'(ptr_upd),  32'(m_upd));
      chk("m_level",    32'(level),    32'(m_lvl));
      chk("m_empty",    32'(empty),    32'(m_lvl == 0));
      chk("m_full",     32'(full),     32'(m_lvl >= 8));
      chk("m_aempty",   32'(aempty),   32'(m_lvl <= AE));
      chk("m_afull",    32'(afull),    32'(m_lvl >= AF));
      chk("m_gray_err", 32'(gray_err), 32'(m_err));
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_bin"},   32'(bin_out),  32'h0);
      chk({tag, "_upd"},   32'(ptr_upd),  32'h0);
      chk({tag, "_lvl"},   32'(level),    32'h0);
      chk({tag, "_empty"}, 32'(empty),    32'h1);
      chk({tag, "_aempty"},32'(aempty),   32'h1);
      chk({tag, "_full"},  32'(full),     32'h0);
      chk({tag, "_afull"}, 32'(afull),    32'h0);
      chk({tag, "_err"},   32'(gray_err), 32'h0);
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      check_model();
   endtask

   logic [PW-1:0] seq_g [3];
   logic [PW-1:0] seq_b [3];
   logic [PW-1:0] prev_b;
   logic [PW-1:0] rb;

   initial begin
      seq_g = '{4'b0001, 4'b0011, 4'b0010};
      seq_b = '{4'd1, 4'd2, 4'd3};

      // Reset held for three cycles with a non-zero remote pointer.
      repeat (3) begin
         tick();
         chk_reset_vals("reset");
      end
      gray_in   = 4'b0000;
      ptr_local = 4'b0000;
      rst_n     = 1'b1;
      repeat (S + 2) tick();

      // Count-up: each value lands exactly S+1 edges after its step.
      prev_b = '0;
      for (int k = 0; k < 3; k++) begin
         gray_in = seq_g[k];
         repeat (S) begin
            tick();
            chk("lat_hold", 32'(bin_out), 32'(prev_b));
         end
         tick();
         chk("lat_arrive", 32'(bin_out), 32'(seq_b[k]));
         chk("upd_pulse",  32'(ptr_upd), 32'h1);
         chk("lvl_count",  32'(level),   32'(seq_b[k]));
         chk("empty_fall", 32'(empty),   32'h0);
         tick();
         chk("upd_once",   32'(ptr_upd), 32'h0);
         prev_b = seq_b[k];
      end

      // Wrap and full.
      ptr_local = 4'b0111;
      gray_in   = 4'b1100;
      repeat (S + 1) tick();
      chk("wrap_lvl1", 32'(level), 32'h1);
      ptr_local = 4'b0000;
      tick();
      chk("full_lvl",   32'(level), 32'h8);
      chk("full_flag",  32'(full),  32'h1);
      chk("afull_flag", 32'(afull), 32'h1);
      // The 0010 -> 1100 jump is a multi-bit change; clear it before the next step.
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("clr_before_wrap", 32'(gray_err), 32'h0);

      // Wrap 1111 -> 0000 is a single Gray-bit change.
      gray_in = 4'b1000;
      repeat (S + 1) tick();
      chk("wrap_bin15", 32'(bin_out), 32'hF);
      gray_in = 4'b0000;
      repeat (S + 1) tick();
      chk("wrap_bin0",   32'(bin_out),  32'h0);
      chk("wrap_no_err", 32'(gray_err), 32'h0);

      // Multi-bit jump sets the sticky error S+1 edges later.
      gray_in = 4'b0011;
      repeat (S) begin
         tick();
         chk("err_not_yet", 32'(gray_err), 32'h0);
      end
      tick();
      chk("err_set", 32'(gray_err), 32'h1);
      // A second jump detected in the same cycle as err_clr keeps it set.
      gray_in = 4'b0101;
      repeat (S) tick();
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("err_set_wins", 32'(gray_err), 32'h1);
      tick();
      chk("err_sticky", 32'(gray_err), 32'h1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("err_cleared", 32'(gray_err), 32'h0);

      // Asynchronous reset while level is 5.
      gray_in   = 4'b0111;
      ptr_local = 4'b0000;
      repeat (S + 1) tick();
      chk("pre_rst_lvl", 32'(level), 32'h5);
      #2 rst_n = 1'b0;
      #1 chk_reset_vals("async_rst");
      tick();
      rst_n = 1'b1;
      repeat (S) begin
         tick();
         chk("rel_hold", 32'(bin_out), 32'h0);
      end
      tick();
      chk("rel_bin", 32'(bin_out), 32'h5);
      chk("rel_lvl", 32'(level),   32'h5);

      // Random traffic: mostly legal increments, occasional corrupt jumps,
      // local pointer moves and clear pulses.
      rb = 4'd5;
      for (int n = 0; n < 400; n++) begin
         int r;
         r = int'($urandom_range(0, 9));
         if (r < 5) begin
            rb      = rb + 1'b1;
            gray_in = enc(rb);
         end else if (r == 5) begin
            gray_in = PW'($urandom);
         end
         if ($urandom_range(0, 3) == 0) begin
            ptr_local = rb - PW'($urandom_range(0, 9));
         end
         err_clr = ($urandom_range(0, 7) == 0);
         tick();
      end
      err_clr = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/corefifo_gray_ptr_sync.md
# corefifo_gray_ptr_sync

Synchronises a Gray-coded pointer arriving from the opposite FIFO clock domain, converts it to binary, and derives fill level and status flags against the local binary pointer. One instance sits in each domain of the async FIFO: in the read domain it takes the write pointer and produces empty/almost-empty; in the write domain it takes the read pointer and produces full/almost-full. It adds parametrised synchroniser depth, registered output, update strobe and Gray-integrity checking.

## Interface
- ADDRWIDTH, 3: FIFO address width. Pointers are ADDRWIDTH+1 bits and depth is 2^ADDRWIDTH.
- SYNC_STAGES, 2: number of synchroniser flops; legal range 2..4.
- AFULL_TH, 6: almost-full asserts when level >= AFULL_TH.
- AEMPTY_TH, 1: almost-empty asserts when level <= AEMPTY_TH.
- CHECK_GRAY, 1: enables the multi-bit-change detector. When 0, gray_err is tied to 0.
- clk  in  1  domain clock.
- rst_n  in  1  asynchronous active-low reset.
- gray_in  in  ADDRWIDTH+1  remote Gray pointer, asynchronous to clk.
- ptr_local  in  ADDRWIDTH+1  local binary pointer, synchronous to clk.
- err_clr  in  1  clears the sticky gray_err.
- bin_out  out  ADDRWIDTH+1  synchronised remote pointer, binary, registered.
- ptr_upd  out  1  one-cycle pulse when bin_out changed at the last edge.
- level  out  ADDRWIDTH+1  bin_out minus ptr_local, modulo 2^(ADDRWIDTH+1).
- empty, aempty, full, afull  out  1 each  registered status flags.
- gray_err  out  1  sticky: the synchronised Gray value changed by more than one bit between consecutive cycles.

## Operation
- Synchroniser: gray_in feeds sync[0], which feeds through to sync[SYNC_STAGES-1]. There is no logic between stages.
- Conversion: bin_c[ADDRWIDTH] = g[ADDRWIDTH]; bin_c[i-1] = bin_c[i] XOR g[i-1], where g = sync[SYNC_STAGES-1]. Purely combinational, then registered into bin_out.
- ptr_upd is registered as (bin_c != bin_out).
- Level: lvl_c = bin_c − ptr_local, computed in ADDRWIDTH+1 bits with wrap, and registered into level.
- Flags, each registered from lvl_c:
  - empty = (lvl_c == 0)
  - full = (lvl_c >= 2^ADDRWIDTH)
  - aempty = (lvl_c <= AEMPTY_TH)
  - afull = (lvl_c >= AFULL_TH)
- Out-of-range level: a value above 2^ADDRWIDTH is illegal. It still reports full=1, and the value is not clamped.
- Gray check: prev_g holds the previous g. If popcount(g XOR prev_g) > 1, gray_err sets on the next edge. A change of exactly one bit, or no change, is legal.
- Clearing gray_err: err_clr=1 clears gray_err. If a new error occurs in the same cycle as err_clr, set wins.
- Reset values (async, rst_n=0):
  - all sync stages, prev_g, bin_out and level = 0
  - ptr_upd = 0, full = 0, empty = 1, gray_err = 0
  - aempty = (0 <= AEMPTY_TH), which is 1 for any legal threshold
  - afull = (0 >= AFULL_TH), which is 0 when AFULL_TH > 0
- Release from reset happens on the first clk edge with rst_n high. There is no other internal state.

## Timing
- Remote-pointer latency: a stable gray_in change is visible on bin_out, level and the flags SYNC_STAGES+1 edges later. ptr_upd pulses in the same cycle bin_out changes.
- Local-pointer latency: a ptr_local change is reflected in level and the flags one edge later.
- Simultaneous remote and local change: level uses the new bin_c and the current ptr_local in the same cycle. No priority is needed.
- Wrap-around: gray 1000 (bin 1111, ADDRWIDTH=3) to gray 0000 (bin 0000) is a single-bit change. It must give no gray_err, and level is computed with modulo arithmetic.
- Reset mid-operation: all outputs take their reset values immediately and asynchronously. No pulse on ptr_upd is generated on release.

## Structure
- Shared package corefifo_pkg holds:
  - function gray2bin(width-generic)
  - function bin2gray (used by the bench and by the write-side counter)
  - function popcount_gt1
  - localparam PTRW = ADDRWIDTH+1
- One sub-module, corefifo_gray2bin_comb: the combinational converter, instantiated once on g.
- The synchroniser is a generate loop over SYNC_STAGES.
- Parameter checks are elaboration-time: SYNC_STAGES must be in 2..4, AEMPTY_TH < AFULL_TH, and AFULL_TH <= 2^ADDRWIDTH.

## Test plan
- Reset: hold rst_n=0 for 3 cycles while gray_in=0101 -> bin_out=0, level=0, empty=1, aempty=1, full=0, afull=0, gray_err=0 throughout.
- Count-up latency: with ptr_local=0, step gray_in through 0000, 0001, 0011, 0010 (bin 0..3), one every 4 cycles -> each bin_out value appears exactly SYNC_STAGES+1 edges after its step. ptr_upd pulses once per step. level goes 0, 1, 2, 3, and empty falls with the first step.
- Wrap and full: ptr_local=0111, then gray_in=1100 (bin 1000) -> level=0001. Then ptr_local=0000 with gray_in=1100 -> level=1000, full=1, afull=1, and the flags update one edge after the ptr_local change.
- Wrap, no false error: gray_in 1000 to 0000 -> bin_out goes 1111 to 0000 with gray_err staying 0.
- Gray error: gray_in jumps 0000 to 0011 -> gray_err=1 at SYNC_STAGES+1 edges. It stays set after err_clr if a second jump (0011 to 0101) coincides with err_clr, and clears on a following lone err_clr pulse.
- Reset mid-run: assert rst_n=0 while level=5 -> all outputs return to reset values asynchronously. After release with stable gray_in=0111 (bin 0101), the outputs resume with bin_out=0101 after SYNC_STAGES+1 edges.
